// File: rtl/axi4_lite_sram_slave_pkg.sv
// Shared constants for the AXI4-Lite SRAM slave: default widths, response
// codes and the read/write FSM state encodings.
package axi4_lite_sram_slave_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;
   localparam int DEF_RESP_WIDTH = 2;
   localparam int DEF_DEPTH      = 1024;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] RD_RESP = 2'd2;

   localparam logic [1:0] WR_IDLE = 2'd0;
   localparam logic [1:0] WR_WAIT = 2'd1;
   localparam logic [1:0] WR_RESP = 2'd2;

   localparam int LAT_WIDTH = 4;

endpackage

// File: rtl/axi4_lite_sram_slave_sram_array.sv
// Word-organised storage: one byte-masked synchronous write port and one
// synchronous read port. Contents are never reset. A read and a write to the
// same word on the same edge return the value held before the write.
module axi4_lite_sram_slave_sram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   localparam int MASK_WIDTH = DATA_WIDTH / 8,
   localparam int IDX_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  iClock,
   input  logic                  wr_en,
   input  logic [IDX_WIDTH-1:0]  wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [MASK_WIDTH-1:0] wr_strb,
   input  logic                  rd_en,
   input  logic [IDX_WIDTH-1:0]  rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Byte-lane write and registered read share one edge; the read sees old data.
   always_ff @(posedge iClock) begin
      if (wr_en) begin
         for (int b = 0; b < MASK_WIDTH; b++) begin
            if (wr_strb[b]) begin
               mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_idx];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave memory model with independent read and write channels,
// programmable response latency and SLVERR on out-of-range addresses.
//
// Read FSM
//   state   | meaning
//   RD_IDLE | ar_ready high, waiting for an address
//   RD_WAIT | counting latency, then one cycle for the array read to return
//   RD_RESP | r_valid high, data/resp held until r_ready
// Write FSM
//   state   | meaning
//   WR_IDLE | capturing AW and W independently; commits once both are held
//   WR_WAIT | counting latency after the commit
//   WR_RESP | b_valid high, resp held until b_ready
module axi4_lite_sram_slave
   import axi4_lite_sram_slave_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    MASK_WIDTH = DATA_WIDTH / 8,
   parameter int                    RESP_WIDTH = DEF_RESP_WIDTH,
   parameter int                    DEPTH      = DEF_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
   parameter int                    RD_LATENCY = 1,
   parameter int                    WR_LATENCY = 1
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  pAXI4_ar_valid,
   output logic                  pAXI4_ar_ready,
   input  logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
   output logic                  pAXI4_r_valid,
   input  logic                  pAXI4_r_ready,
   output logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
   output logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
   input  logic                  pAXI4_aw_valid,
   output logic                  pAXI4_aw_ready,
   input  logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
   input  logic                  pAXI4_w_valid,
   output logic                  pAXI4_w_ready,
   input  logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
   input  logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
   output logic                  pAXI4_b_valid,
   input  logic                  pAXI4_b_ready,
   output logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp
);

   localparam int                   IDX_WIDTH  = $clog2(DEPTH);
   localparam int                   BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH:0]  SPAN       = (ADDR_WIDTH+1)'(DEPTH * (DATA_WIDTH / 8));
   localparam logic [LAT_WIDTH-1:0] RD_LAT     = LAT_WIDTH'(RD_LATENCY);
   localparam logic [LAT_WIDTH-1:0] WR_LAT     = LAT_WIDTH'(WR_LATENCY);
   localparam logic [RESP_WIDTH-1:0] R_OKAY    = RESP_WIDTH'(RESP_OKAY);
   localparam logic [RESP_WIDTH-1:0] R_SLVERR  = RESP_WIDTH'(RESP_SLVERR);

   // One extra bit keeps the borrow of (addr - BASE_ADDR) so addresses below
   // the base are rejected instead of wrapping into the array.
   function automatic logic [ADDR_WIDTH:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} - {1'b0, BASE_ADDR};
   endfunction

   function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH:0] off;
      off = addr_offset(a);
      return !off[ADDR_WIDTH] && (off < SPAN);
   endfunction

   function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
      return IDX_WIDTH'(addr_offset(a) >> BYTE_SHIFT);
   endfunction

   logic                  ar_ok, aw_ok;
   logic [IDX_WIDTH-1:0]  ar_idx, aw_idx;

   assign ar_ok  = addr_in_range(pAXI4_ar_bits_addr);
   assign ar_idx = addr_index(pAXI4_ar_bits_addr);
   assign aw_ok  = addr_in_range(pAXI4_aw_bits_addr);
   assign aw_idx = addr_index(pAXI4_aw_bits_addr);

   // ---------------- read channel ----------------
   logic [1:0]            rd_state_q, rd_state_d;
   logic [LAT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic [IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
   logic                  rd_ok_q, rd_ok_d;
   logic                  rd_fetch_q, rd_fetch_d;
   logic                  r_valid_q, r_valid_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   logic [RESP_WIDTH-1:0] r_resp_q, r_resp_d;
   logic                  sram_rd_en;
   logic [DATA_WIDTH-1:0] sram_rd_data;

   assign pAXI4_ar_ready    = (rd_state_q == RD_IDLE);
   assign pAXI4_r_valid     = r_valid_q;
   assign pAXI4_r_bits_data = r_data_q;
   assign pAXI4_r_bits_resp = r_resp_q;

   // Read FSM next state; rd_fetch marks the cycle the array read is in flight.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_idx_d   = rd_idx_q;
      rd_ok_d    = rd_ok_q;
      rd_fetch_d = rd_fetch_q;
      r_valid_d  = r_valid_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      sram_rd_en = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            if (pAXI4_ar_valid) begin
               rd_idx_d   = ar_idx;
               rd_ok_d    = ar_ok;
               rd_cnt_d   = RD_LAT;
               rd_fetch_d = 1'b0;
               rd_state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_fetch_q) begin
               r_valid_d  = 1'b1;
               r_data_d   = rd_ok_q ? sram_rd_data : '0;
               r_resp_d   = rd_ok_q ? R_OKAY : R_SLVERR;
               rd_fetch_d = 1'b0;
               rd_state_d = RD_RESP;
            end else if (rd_cnt_q == '0) begin
               sram_rd_en = rd_ok_q;
               rd_fetch_d = 1'b1;
            end else begin
               rd_cnt_d = rd_cnt_q - 1'b1;
            end
         end
         RD_RESP: begin
            if (pAXI4_r_ready) begin
               r_valid_d  = 1'b0;
               r_data_d   = '0;
               r_resp_d   = '0;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Read channel registers.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         rd_state_q <= RD_IDLE;
         rd_cnt_q   <= '0;
         rd_idx_q   <= '0;
         rd_ok_q    <= 1'b0;
         rd_fetch_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_idx_q   <= rd_idx_d;
         rd_ok_q    <= rd_ok_d;
         rd_fetch_q <= rd_fetch_d;
         r_valid_q  <= r_valid_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
      end
   end

   // ---------------- write channel ----------------
   logic [1:0]            wr_state_q, wr_state_d;
   logic [LAT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic                  aw_cap_q, aw_cap_d;
   logic                  w_cap_q, w_cap_d;
   logic [IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
   logic                  wr_ok_q, wr_ok_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [MASK_WIDTH-1:0] w_strb_q, w_strb_d;
   logic [RESP_WIDTH-1:0] wr_pend_q, wr_pend_d;
   logic                  b_valid_q, b_valid_d;
   logic [RESP_WIDTH-1:0] b_resp_q, b_resp_d;

   logic                  wr_idle, aw_fire, w_fire, wr_commit;
   logic [IDX_WIDTH-1:0]  cm_idx;
   logic                  cm_ok;
   logic [DATA_WIDTH-1:0] cm_data;
   logic [MASK_WIDTH-1:0] cm_strb;
   logic                  sram_wr_en;

   assign wr_idle   = (wr_state_q == WR_IDLE);
   assign pAXI4_aw_ready    = wr_idle && !aw_cap_q;
   assign pAXI4_w_ready     = wr_idle && !w_cap_q;
   assign pAXI4_b_valid     = b_valid_q;
   assign pAXI4_b_bits_resp = b_resp_q;

   assign aw_fire   = pAXI4_aw_valid && pAXI4_aw_ready;
   assign w_fire    = pAXI4_w_valid && pAXI4_w_ready;
   assign wr_commit = wr_idle && (aw_cap_q || aw_fire) && (w_cap_q || w_fire);

   // The commit can happen on the same edge as the second capture, so take
   // each half from its holding register if present, otherwise from the bus.
   assign cm_idx  = aw_cap_q ? wr_idx_q : aw_idx;
   assign cm_ok   = aw_cap_q ? wr_ok_q  : aw_ok;
   assign cm_data = w_cap_q  ? w_data_q : pAXI4_w_bits_data;
   assign cm_strb = w_cap_q  ? w_strb_q : pAXI4_w_bits_strb;

   // Write FSM next state: capture, commit, latency count, response.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      aw_cap_d   = aw_cap_q;
      w_cap_d    = w_cap_q;
      wr_idx_d   = wr_idx_q;
      wr_ok_d    = wr_ok_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      wr_pend_d  = wr_pend_q;
      b_valid_d  = b_valid_q;
      b_resp_d   = b_resp_q;
      sram_wr_en = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (wr_commit) begin
               sram_wr_en = cm_ok;
               aw_cap_d   = 1'b0;
               w_cap_d    = 1'b0;
               wr_cnt_d   = WR_LAT;
               wr_pend_d  = cm_ok ? R_OKAY : R_SLVERR;
               wr_state_d = WR_WAIT;
            end else begin
               if (aw_fire) begin
                  aw_cap_d = 1'b1;
                  wr_idx_d = aw_idx;
                  wr_ok_d  = aw_ok;
               end
               if (w_fire) begin
                  w_cap_d  = 1'b1;
                  w_data_d = pAXI4_w_bits_data;
                  w_strb_d = pAXI4_w_bits_strb;
               end
            end
         end
         WR_WAIT: begin
            if (wr_cnt_q == '0) begin
               b_valid_d  = 1'b1;
               b_resp_d   = wr_pend_q;
               wr_state_d = WR_RESP;
            end else begin
               wr_cnt_d = wr_cnt_q - 1'b1;
            end
         end
         WR_RESP: begin
            if (pAXI4_b_ready) begin
               b_valid_d  = 1'b0;
               b_resp_d   = '0;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Write channel registers.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         wr_state_q <= WR_IDLE;
         wr_cnt_q   <= '0;
         aw_cap_q   <= 1'b0;
         w_cap_q    <= 1'b0;
         wr_idx_q   <= '0;
         wr_ok_q    <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         wr_pend_q  <= '0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_cnt_q   <= wr_cnt_d;
         aw_cap_q   <= aw_cap_d;
         w_cap_q    <= w_cap_d;
         wr_idx_q   <= wr_idx_d;
         wr_ok_q    <= wr_ok_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         wr_pend_q  <= wr_pend_d;
         b_valid_q  <= b_valid_d;
         b_resp_q   <= b_resp_d;
      end
   end

   axi4_lite_sram_slave_sram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_sram_array (
      .iClock  (iClock),
      .wr_en   (sram_wr_en),
      .wr_idx  (cm_idx),
      .wr_data (cm_data),
      .wr_strb (cm_strb),
      .rd_en   (sram_rd_en),
      .rd_idx  (rd_idx_q),
      .rd_data (sram_rd_data)
   );

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Bench for axi4_lite_sram_slave: two instances (latency 0/0 and 3/2), directed
// steps followed by random traffic checked against a word-array model.
module tb_axi4_lite_sram_slave;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int RDL [2] = '{0, 3};
   localparam int WRL [2] = '{0, 2};

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ar_valid, ar_ready, r_valid, r_ready;
   logic [1:0]  aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic [31:0] ar_addr [2];
   logic [31:0] aw_addr [2];
   logic [31:0] w_data  [2];
   logic [3:0]  w_strb  [2];
   logic [31:0] r_data  [2];
   logic [1:0]  r_resp  [2];
   logic [1:0]  b_resp  [2];

   int tests = 0;
   int fails = 0;

   logic [31:0] mdl [2][DEPTH];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi4_lite_sram_slave #(
         .RD_LATENCY (RDL[g]),
         .WR_LATENCY (WRL[g])
      ) u_dut (
         .iClock             (clk),
         .iReset             (rst),
         .pAXI4_ar_valid     (ar_valid[g]),
         .pAXI4_ar_ready     (ar_ready[g]),
         .pAXI4_ar_bits_addr (ar_addr[g]),
         .pAXI4_r_valid      (r_valid[g]),
         .pAXI4_r_ready      (r_ready[g]),
         .pAXI4_r_bits_data  (r_data[g]),
         .pAXI4_r_bits_resp  (r_resp[g]),
         .pAXI4_aw_valid     (aw_valid[g]),
         .pAXI4_aw_ready     (aw_ready[g]),
         .pAXI4_aw_bits_addr (aw_addr[g]),
         .pAXI4_w_valid      (w_valid[g]),
         .pAXI4_w_ready      (w_ready[g]),
         .pAXI4_w_bits_data  (w_data[g]),
         .pAXI4_w_bits_strb  (w_strb[g]),
         .pAXI4_b_valid      (b_valid[g]),
         .pAXI4_b_ready      (b_ready[g]),
         .pAXI4_b_bits_resp  (b_resp[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int hold);
      int aw_at, w_at, cyc, lat;
      bit aw_done, w_done, awf, wf;
      logic [1:0] exp_resp;
      aw_at = (lead > 0) ? lead : 0;
      w_at  = (lead < 0) ? -lead : 0;
      aw_addr[d] = addr;
      w_data[d]  = data;
      w_strb[d]  = strb;
      aw_done = 0; w_done = 0; cyc = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (!aw_done && cyc >= aw_at) aw_valid[d] = 1'b1;
         if (!w_done && cyc >= w_at) w_valid[d] = 1'b1;
         awf = aw_valid[d] && aw_ready[d];
         wf  = w_valid[d] && w_ready[d];
         step();
         cyc++;
         if (awf) begin aw_done = 1; aw_valid[d] = 1'b0; end
         if (wf)  begin w_done = 1;  w_valid[d]  = 1'b0; end
         if (aw_done && !w_done) chk($sformatf("d%0d aw_ready_held", d), 32'(aw_ready[d]), 0);
         if (w_done && !aw_done) chk($sformatf("d%0d w_ready_held", d), 32'(w_ready[d]), 0);
      end
      aw_valid[d] = 1'b0;
      w_valid[d]  = 1'b0;
      chk($sformatf("d%0d wr_capture", d), 32'(aw_done && w_done), 1);
      exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
      if (in_rng(addr))
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[d][widx(addr)][8*b +: 8] = data[8*b +: 8];
      lat = 0;
      while (!b_valid[d] && lat < 40) begin
         step();
         lat++;
      end
      chk($sformatf("d%0d b_latency", d), 32'(lat), 32'(WRL[d] + 1));
      chk($sformatf("d%0d b_resp", d), 32'(b_resp[d]), 32'(exp_resp));
      chk($sformatf("d%0d aw_ready_in_resp", d), 32'(aw_ready[d]), 0);
      for (int h = 0; h < hold; h++) begin
         step();
         chk($sformatf("d%0d b_valid_hold", d), 32'(b_valid[d]), 1);
         chk($sformatf("d%0d b_resp_hold", d), 32'(b_resp[d]), 32'(exp_resp));
      end
      b_ready[d] = 1'b1;
      step();
      b_ready[d] = 1'b0;
      chk($sformatf("d%0d b_valid_clear", d), 32'(b_valid[d]), 0);
      chk($sformatf("d%0d b_resp_clear", d), 32'(b_resp[d]), 0);
      chk($sformatf("d%0d aw_w_ready_back", d), 32'({aw_ready[d], w_ready[d]}), 32'h3);
      step();
      chk($sformatf("d%0d b_single_pulse", d), 32'(b_valid[d]), 0);
   endtask

   task automatic do_read(input int d, input logic [31:0] addr, input int hold);
      int cyc, lat;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      ar_addr[d]  = addr;
      ar_valid[d] = 1'b1;
      cyc = 0;
      while (!ar_ready[d] && cyc < 40) begin
         step();
         cyc++;
      end
      chk($sformatf("d%0d ar_ready_idle", d), 32'(ar_ready[d]), 1);
      step();
      ar_valid[d] = 1'b0;
      chk($sformatf("d%0d ar_ready_busy", d), 32'(ar_ready[d]), 0);
      lat = 0;
      while (!r_valid[d] && lat < 40) begin
         step();
         lat++;
      end
      exp_data = in_rng(addr) ? mdl[d][widx(addr)] : 32'h0;
      exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
      chk($sformatf("d%0d r_latency", d), 32'(lat), 32'(RDL[d] + 2));
      chk($sformatf("d%0d r_data @%h", d, addr), r_data[d], exp_data);
      chk($sformatf("d%0d r_resp @%h", d, addr), 32'(r_resp[d]), 32'(exp_resp));
      for (int h = 0; h < hold; h++) begin
         step();
         chk($sformatf("d%0d r_valid_hold", d), 32'(r_valid[d]), 1);
         chk($sformatf("d%0d r_data_hold", d), r_data[d], exp_data);
         chk($sformatf("d%0d ar_ready_hold", d), 32'(ar_ready[d]), 0);
      end
      r_ready[d] = 1'b1;
      step();
      r_ready[d] = 1'b0;
      chk($sformatf("d%0d r_valid_clear", d), 32'(r_valid[d]), 0);
      chk($sformatf("d%0d r_data_clear", d), r_data[d], 0);
      chk($sformatf("d%0d r_resp_clear", d), 32'(r_resp[d]), 0);
      chk($sformatf("d%0d ar_ready_after", d), 32'(ar_ready[d]), 1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idxs [8];
      int k;
      logic [31:0] a;

      rst      = 1'b1;
      ar_valid = 2'b11;
      r_ready  = '0;
      aw_valid = '0;
      w_valid  = '0;
      b_ready  = '0;
      for (int d = 0; d < 2; d++) begin
         ar_addr[d] = BASE;
         aw_addr[d] = BASE;
         w_data[d]  = '0;
         w_strb[d]  = '0;
      end

      // reset held three cycles with ar_valid asserted
      repeat (3) begin
         step();
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_r_valid", d), 32'(r_valid[d]), 0);
            chk($sformatf("d%0d rst_b_valid", d), 32'(b_valid[d]), 0);
         end
      end
      rst      = 1'b0;
      ar_valid = '0;
      step();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d post_rst_readies", d),
             32'({ar_ready[d], aw_ready[d], w_ready[d]}), 32'h7);
         chk($sformatf("d%0d post_rst_r_data", d), r_data[d], 0);
         chk($sformatf("d%0d post_rst_resps", d), 32'({r_resp[d], b_resp[d]}), 0);
      end

      // write then read, zero latency
      do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      do_read (0, 32'h8000_0010, 0);

      // partial strobe
      do_write(0, 32'h8000_0010, 32'h1122_3344, 4'hF, 0, 1);
      do_write(0, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101, 0, 0);
      do_read (0, 32'h8000_0010, 1);

      // W three cycles before AW
      do_write(0, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 3, 0);
      do_read (0, 32'h8000_0004, 0);

      // longer latencies, AW first, read backpressure
      do_write(1, 32'h8000_0020, 32'h0BAD_C0DE, 4'hF, -2, 2);
      do_read (1, 32'h8000_0020, 5);

      // out of range on both sides, array untouched
      do_read (0, 32'h7FFF_FFFC, 0);
      do_write(0, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, 0);
      do_write(0, 32'h8000_0FFC, 32'h8765_4321, 4'hF, 0, 0);
      do_write(0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0);
      do_read (0, 32'h8000_0000, 0);
      do_read (0, 32'h8000_0FFC, 0);
      do_read (0, 32'h8000_1000, 0);

      // all-zero strobe is a no-op write with OKAY
      do_write(0, 32'h8000_0010, 32'h5555_5555, 4'h0, 1, 0);
      do_read (0, 32'h8000_0010, 0);

      // random traffic against the model
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) begin
            idxs[i] = int'($urandom_range(0, DEPTH - 1));
            do_write(d, BASE + 32'(idxs[i] * 4), $urandom, 4'hF, 0, 0);
         end
         for (int n = 0; n < 14; n++) begin
            k = int'($urandom_range(0, 7));
            a = BASE + 32'(idxs[k] * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'(DEPTH * 4);
            if ($urandom_range(0, 1) == 1)
               do_write(d, a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                        int'($urandom_range(0, 2)));
            else
               do_read(d, a, int'($urandom_range(0, 3)));
         end
      end

      // reset mid-read: response dropped, contents kept
      ar_addr[1]  = 32'h8000_0020;
      ar_valid[1] = 1'b1;
      step();
      ar_valid[1] = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("d1 mid_rst_no_r_valid", 32'(r_valid[1]), 0);
      end
      do_read(1, 32'h8000_0020, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
